// File: rtl/uop_queue.sv
// -----------------------------------------------------------------------------
// uop_queue
//
// Per-thread micro-op buffer that sits between the decoder and the dual-stream
// scheduler. One instance serves one stream. Decoded uops are pushed in,
// together with an end-of-instruction flag, and the scheduler sees the head
// entry combinationally. A copy of the most recently issued uop is kept in
// uop_last so the scheduler can run its store and register-dependency checks
// against it.
//
// Parameters
//   DEPTH      number of entries (power of two, 2..32)
//   UOP_W      uop width
//   LAST_RST   value loaded into uop_last on reset and on flush
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   flush         synchronous clear of the queue and of uop_last
//   push_valid    decoder offers a uop
//   push_uop      uop payload
//   push_is_last  offered uop is the last uop of its instruction
//   push_ready    queue can accept a push this cycle
//   pop           scheduler issued the head uop this cycle
//   uop_valid     head entry present
//   uop_next      head uop payload (zero when empty)
//   uop_is_last   head end-of-instruction flag (zero when empty)
//   uop_last      last uop issued from this queue
//   count         number of occupied entries
//   full          count == DEPTH
//   empty         count == 0
// -----------------------------------------------------------------------------
module uop_queue #(
    parameter int                DEPTH    = 8,
    parameter int                UOP_W    = 20,
    parameter logic [UOP_W-1:0]  LAST_RST = 20'h00F00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push_valid,
    input  logic [UOP_W-1:0]          push_uop,
    input  logic                      push_is_last,
    output logic                      push_ready,
    input  logic                      pop,
    output logic                      uop_valid,
    output logic [UOP_W-1:0]          uop_next,
    output logic                      uop_is_last,
    output logic [UOP_W-1:0]          uop_last,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // Each entry is {is_last, uop}; the flag sits in the top bit.
    logic [UOP_W:0]   storage [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic [UOP_W-1:0] uop_last_q;

    logic             do_push;
    logic             do_pop;
    logic [UOP_W:0]   head_entry;

    // Status flags come straight from the registered occupancy, so push_ready
    // never depends on this cycle's pop. A full queue therefore refuses a push
    // even when the scheduler is popping in the same cycle.
    always_comb begin
        full       = (count_q == COUNT_FULL);
        empty      = (count_q == '0);
        push_ready = ~full;
        count      = count_q;
        uop_last   = uop_last_q;
    end

    // A push needs room and a pop needs something to issue; a pop against an
    // empty queue is simply ignored, which keeps uop_last from being loaded
    // with garbage.
    always_comb begin
        do_push = push_valid & ~full;
        do_pop  = pop & ~empty;
    end

    // The head is presented from registered state only. When the queue is
    // empty the payload and flag are forced to zero so the scheduler cannot
    // act on a stale is_last left behind in the storage array.
    always_comb begin
        head_entry  = storage[rptr];
        uop_valid   = ~empty;
        uop_next    = '0;
        uop_is_last = 1'b0;
        if (!empty) begin
            uop_next    = head_entry[UOP_W-1:0];
            uop_is_last = head_entry[UOP_W];
        end
    end

    // Storage array has no reset: entries are only ever read after being
    // written, and a flush just rewinds the pointers. A push in a flush cycle
    // may still land in the array, but the pointers are rewound so it is
    // never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wptr] <= {push_is_last, push_uop};
        end
    end

    // Pointer, occupancy and last-issued state. Flush wins over any push or
    // pop in the same cycle. Pointers are exactly AW bits wide so they wrap
    // modulo DEPTH on their own. Push and pop are independent; when both fire
    // the occupancy is left alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            uop_last_q <= LAST_RST;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            uop_last_q <= LAST_RST;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr       <= rptr + AW'(1);
                uop_last_q <= head_entry[UOP_W-1:0];
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule
